// File: rtl/simplez_pkg.sv
// Shared Simplez memory-port constants and loader FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// The state codes live here so a future port arbiter can decode busy states
// without reaching into the loader.
package simplez_pkg;

    localparam int AW       = 9;
    localparam int DW       = 12;
    localparam int MEM_SIZE = 512;

    localparam int SW = 4;

    localparam logic [SW-1:0] ST_IDLE    = 4'd0;
    localparam logic [SW-1:0] ST_LD_LO   = 4'd1;
    localparam logic [SW-1:0] ST_LD_HI   = 4'd2;
    localparam logic [SW-1:0] ST_LD_WR   = 4'd3;
    localparam logic [SW-1:0] ST_DP_RD   = 4'd4;
    localparam logic [SW-1:0] ST_DP_WAIT = 4'd5;
    localparam logic [SW-1:0] ST_DP_LO   = 4'd6;
    localparam logic [SW-1:0] ST_DP_HI   = 4'd7;
    localparam logic [SW-1:0] ST_FIN     = 4'd8;

    // True for every state in which the loader owns the memory port.
    function automatic logic state_is_busy(input logic [SW-1:0] st);
        return st != ST_IDLE;
    endfunction

    // Load-side states: the only states in which rx bytes are consumed.
    function automatic logic state_is_load(input logic [SW-1:0] st);
        return (st == ST_LD_LO) || (st == ST_LD_HI) || (st == ST_LD_WR);
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Bundle of the loader's byte streams (uart rx/tx) and Simplez memory port.
// Latency: n/a (wires only).
// Backpressure: tx side is valid/ready; rx side is a strobe with no backpressure.
// Ports (master = loader view):
//   rx_data/rx_valid  in   received byte + one-cycle strobe
//   tx_data/tx_valid  out  byte to transmit, held until tx_ready
//   tx_ready          in   transmitter accepts the byte this cycle
//   mem_addr/mem_wr/mem_din  out  memory address, write enable, write data
//   mem_dout          in   memory read data (registered by memory on negedge)
interface mem_loader_if;
    import simplez_pkg::*;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_dout,
        output tx_data, tx_valid, mem_addr, mem_wr, mem_din
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_dout,
        input  tx_data, tx_valid, mem_addr, mem_wr, mem_din
    );

endinterface

// File: rtl/mem_loader.sv
// Loads Simplez memory from a uart byte stream, or dumps it as byte pairs.
// Latency: one write per two rx bytes; dump takes 2 cycles read + 2 tx handshakes per word.
// Backpressure: tx_valid/tx_data held until tx_ready; rx has none (bytes outside load states dropped).
// Ports: clk, rstn (sync active-low), load/dump start requests (sampled in IDLE only),
//        bus (mem_loader_if.master: rx/tx streams and memory port), busy, done (1-cycle pulse).
module mem_loader
    import simplez_pkg::*;
#(
    parameter int NWORDS = 512
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic dump,
    mem_loader_if.master bus,
    output logic busy,
    output logic done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    logic [SW-1:0] state;
    logic [DW-1:0] word;
    logic          last_word;

    assign last_word = (bus.mem_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            word         <= '0;
            bus.mem_addr <= '0;
            bus.mem_wr   <= 1'b0;
            bus.mem_din  <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Single-cycle strobes default low; states below raise them.
            bus.mem_wr <= 1'b0;
            done       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    bus.mem_addr <= '0;
                    if (load) begin
                        state <= ST_LD_LO;
                        busy  <= 1'b1;
                    end else if (dump) begin
                        state <= ST_DP_RD;
                        busy  <= 1'b1;
                    end
                end

                ST_LD_LO: begin
                    if (bus.rx_valid) begin
                        word[7:0] <= bus.rx_data;
                        state     <= ST_LD_HI;
                    end
                end

                ST_LD_HI: begin
                    // Only the low nibble of the second byte is meaningful.
                    if (bus.rx_valid) begin
                        word[11:8]  <= bus.rx_data[3:0];
                        bus.mem_din <= {bus.rx_data[3:0], word[7:0]};
                        bus.mem_wr  <= 1'b1;
                        state       <= ST_LD_WR;
                    end
                end

                ST_LD_WR: begin
                    // The write happens this cycle. A byte arriving now is the
                    // next low byte, unless this was the final word.
                    if (last_word) begin
                        bus.mem_addr <= '0;
                        done         <= 1'b1;
                        state        <= ST_FIN;
                    end else begin
                        bus.mem_addr <= bus.mem_addr + AW'(1);
                        if (bus.rx_valid) begin
                            word[7:0] <= bus.rx_data;
                            state     <= ST_LD_HI;
                        end else begin
                            state <= ST_LD_LO;
                        end
                    end
                end

                ST_DP_RD: begin
                    // Address is presented this cycle; memory registers it on negedge.
                    state <= ST_DP_WAIT;
                end

                ST_DP_WAIT: begin
                    word         <= bus.mem_dout;
                    bus.tx_data  <= bus.mem_dout[7:0];
                    bus.tx_valid <= 1'b1;
                    state        <= ST_DP_LO;
                end

                ST_DP_LO: begin
                    // Low byte accepted: swap straight to the high byte, valid stays up.
                    if (bus.tx_ready) begin
                        bus.tx_data <= {4'b0000, word[11:8]};
                        state       <= ST_DP_HI;
                    end
                end

                ST_DP_HI: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        if (last_word) begin
                            bus.mem_addr <= '0;
                            done         <= 1'b1;
                            state        <= ST_FIN;
                        end else begin
                            bus.mem_addr <= bus.mem_addr + AW'(1);
                            state        <= ST_DP_RD;
                        end
                    end
                end

                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    bus.mem_addr <= '0;
                    bus.tx_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Bus initiator for the Simplez 512x12 program memory. Drives the memory port (addr, wr, data_in) and consumes its registered data_out.
- Two modes:
  - Load: assembles 12-bit words from a UART receive byte stream and writes them sequentially from address 0.
  - Dump: reads memory sequentially and streams each word out as two bytes to a UART transmitter.
- Sits between the UART rx/tx blocks and the memory port mux. The CPU is held off the port while busy=1.

Parameters:
- NWORDS, 512, number of words loaded or dumped per operation, starting at address 0; legal range 1..512.

Ports:
- clk  in  1  system clock; all logic on posedge
- rstn  in  1  reset, synchronous, active-low
- load  in  1  start load; sampled only in IDLE
- dump  in  1  start dump; sampled only in IDLE
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte this cycle when tx_valid=1
- mem_addr  out  9  memory address
- mem_wr  out  1  memory write enable
- mem_din  out  12  write data to memory
- mem_dout  in  12  memory read data (memory registers it on negedge clk)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of an operation

Behaviour:
- Reset: one clock ago is a synchronous, active-low reset. While rstn=0 at a posedge:
  - state goes to IDLE;
  - mem_addr, mem_din and tx_data go to 0;
  - mem_wr, tx_valid, busy and done go to 0.
- Reset mid-operation aborts immediately. No further mem_wr and no tx_valid after reset.
- All outputs are registered on posedge clk.
- Memory timing: the memory samples addr/wr/data_in and updates data_out on negedge.
  - Outputs driven at posedge N are captured at the negedge inside cycle N.
  - Read data is sampled at posedge N+1, so read latency is 1 cycle.
- FSM states: IDLE, LD_LO, LD_HI, LD_WR, DP_RD, DP_WAIT, DP_LO, DP_HI, FIN.
- IDLE:
  - load=1 -> LD_LO; otherwise dump=1 -> DP_RD. If both are high, load wins.
  - mem_addr is 0.
- LD_LO: wait for rx_valid; latch rx_data into word[7:0]; -> LD_HI.
- LD_HI: wait for rx_valid; latch rx_data[3:0] into word[11:8] (rx_data[7:4] ignored); -> LD_WR.
- LD_WR: exactly one cycle.
  - mem_wr=1 and mem_din=word at the current mem_addr.
  - Next: mem_addr==NWORDS-1 -> FIN; else mem_addr+1 and -> LD_LO.
  - An rx_valid arriving in this cycle is taken as the next low byte (latch, go to LD_HI) unless this is the last word. On the last word it is dropped.
- rx_valid is ignored in every state other than LD_LO, LD_HI and LD_WR.
- DP_RD: mem_addr stable; -> DP_WAIT.
- DP_WAIT: latch mem_dout into word; -> DP_LO.
- DP_LO:
  - tx_valid=1, tx_data=word[7:0].
  - On tx_ready=1 -> DP_HI, with tx_data updated and tx_valid staying 1.
- DP_HI:
  - tx_data={4'b0000, word[11:8]}.
  - On tx_ready=1: tx_valid=0; mem_addr==NWORDS-1 -> FIN; else mem_addr+1 and -> DP_RD.
- tx_data and tx_valid must not change while tx_valid=1 and tx_ready=0.
- FIN: done=1 for one cycle; mem_addr cleared to 0; -> IDLE.
- mem_wr is never 1 outside LD_WR. No address wrap: 511 is the last address when NWORDS=512.
- load or dump asserted while busy is ignored; it is not queued.

Decomposition:
- Shared package simplez_pkg holds:
  - localparams AW=9, DW=12, MEM_SIZE=512;
  - the FSM state encoding, so that a future port arbiter can decode busy states.
- No sub-module is needed. The byte-pair pack/unpack is inline.

Test Plan:
- Load, NWORDS=2: bytes 0x06,0x02,0x40,0x00 -> mem_wr pulses at addr 0 (data 12'o1006) and addr 1 (data 12'o0100); then done pulse, busy=0, mem_addr=0.
- Dump, NWORDS=3, memory preset {12'o1006, 12'o0100, 12'o7000}, tx_ready=1 -> tx bytes 0x06,0x02,0x40,0x00,0x00,0x0E; then done.
- Back-pressure on dump: tx_ready=0 for 5 cycles on each byte -> tx_data and tx_valid stable throughout, same byte sequence, no duplicated or lost bytes.
- load and dump asserted together in IDLE -> load mode entered, tx_valid stays 0. A dump pulse during the load is ignored.
- rstn=0 after the first byte of a load -> IDLE next cycle, mem_wr never asserted, busy=0. A following load of 0xFF,0xFF writes 12'hFFF at addr 0.
- NWORDS=512 load, with rx_valid landing in the LD_WR cycle -> byte taken as the next low byte; the last write is at addr 511, then FIN with mem_addr=0. An extra rx_valid in the final LD_WR is dropped.
